// File: rtl/bram_delay_ctrl_pkg.sv
// Shared types for the BRAM delay-line controller.
package bram_delay_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SIZE  = 512;

endpackage

// File: rtl/bram_delay_ctrl_if.sv
// Valid/ready sample stream used on both sides of the delay line.
interface bram_delay_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bram_delay_ctrl_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module simple_dual_ram #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 512,
    parameter int AW    = $clog2(SIZE)
) (
    input  logic             wclk,
    input  logic             write_en,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rclk,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] read_data
);

    logic [WIDTH-1:0] mem [SIZE];

    always_ff @(posedge wclk) begin
        if (write_en) mem[waddr] <= wdata;
    end

    always_ff @(posedge rclk) begin
        read_data <= mem[raddr];
    end

endmodule

// File: rtl/bram_delay_ctrl.sv
// Programmable delay line: each accepted sample reappears `delay` accepts later.
// Pointer sequencing, fill tracking and back-pressure around one dual-port RAM.
module bram_delay_ctrl
    import bram_delay_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int SIZE  = DEF_SIZE,
    localparam int AW    = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        cfg_delay,
    output logic                 cfg_err,
    bram_delay_ctrl_if.slave     src,
    bram_delay_ctrl_if.master    dst,
    output logic                 running,
    output logic [AW-1:0]        fill_cnt
);

    state_t           state;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    raddr_q;
    logic [AW-1:0]    delay_q;
    logic             ovld;
    logic             in_ready;
    logic             accept;
    logic [AW-1:0]    wptr_inc;
    logic [AW-1:0]    rd_addr_next;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] rd_data;

    // start and reset both pre-empt any same-cycle accept
    always_comb begin
        in_ready = 1'b0;
        if (!rst && !start) begin
            case (state)
                ST_FILL: in_ready = 1'b1;
                ST_RUN:  in_ready = !ovld || dst.ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = src.valid && in_ready;

    // compare-and-wrap keeps this correct for non-power-of-two SIZE too
    assign wptr_inc     = (wptr == AW'(SIZE - 1)) ? '0 : wptr + AW'(1);
    assign rd_addr_next = (wptr >= delay_q) ? wptr - delay_q
                                            : AW'(wptr + AW'(SIZE) - delay_q);

    // holding raddr_q re-reads the same entry so out_data is stable under stall
    assign ram_raddr = accept ? rd_addr_next : raddr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wptr     <= '0;
            fill_cnt <= '0;
            raddr_q  <= '0;
            delay_q  <= '0;
            ovld     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (start) begin
                ovld <= 1'b0;
                if (cfg_delay == '0) begin
                    cfg_err <= 1'b1;
                    state   <= ST_IDLE;
                end else begin
                    delay_q  <= cfg_delay;
                    wptr     <= '0;
                    fill_cnt <= '0;
                    state    <= ST_FILL;
                end
            end else begin
                case (state)
                    ST_FILL: begin
                        if (accept) begin
                            wptr     <= wptr_inc;
                            fill_cnt <= fill_cnt + AW'(1);
                            if (fill_cnt == delay_q - AW'(1)) state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (accept) begin
                            wptr    <= wptr_inc;
                            raddr_q <= rd_addr_next;
                            ovld    <= 1'b1;
                        end else if (dst.ready) begin
                            ovld <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    simple_dual_ram #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE),
        .AW    (AW)
    ) u_ram (
        .wclk      (clk),
        .write_en  (accept),
        .waddr     (wptr),
        .wdata     (src.data),
        .rclk      (clk),
        .raddr     (ram_raddr),
        .read_data (rd_data)
    );

    assign src.ready = in_ready;
    assign dst.valid = ovld;
    assign dst.data  = rd_data;
    assign running   = (state == ST_RUN);

endmodule

// File: tb/tb_bram_delay_ctrl.sv
// Scoreboard bench for bram_delay_ctrl: a cycle model predicts handshakes and delayed data.
module tb_bram_delay_ctrl;

    localparam int WIDTH = 16;
    localparam int SIZE  = 512;
    localparam int AW    = 9;

    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] cfg_delay;
    logic          cfg_err;
    logic          running;
    logic [AW-1:0] fill_cnt;

    bram_delay_ctrl_if #(.WIDTH(WIDTH)) src_if ();
    bram_delay_ctrl_if #(.WIDTH(WIDTH)) dst_if ();

    bram_delay_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_delay (cfg_delay),
        .cfg_err   (cfg_err),
        .src       (src_if),
        .dst       (dst_if),
        .running   (running),
        .fill_cnt  (fill_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model state
    int               mst   = M_IDLE;
    int               mdelay = 0;
    int               mfill = 0;
    bit               mov   = 1'b0;
    bit               merr  = 1'b0;
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // drive one cycle at the falling edge, check, then advance the model
    task automatic step(input bit st, input int cd, input bit iv, input int id,
                        input bit ordy, input bit rs);
        bit exp_rdy;
        bit acc;
        start        = st;
        cfg_delay    = AW'(cd);
        src_if.valid = iv;
        src_if.data  = WIDTH'(id);
        dst_if.ready = ordy;
        rst          = rs;
        #1;
        chk("out_valid", 32'(dst_if.valid), 32'(mov));
        chk("running", 32'(running), 32'(mst == M_RUN));
        chk("fill_cnt", 32'(fill_cnt), 32'(mfill));
        chk("cfg_err", 32'(cfg_err), 32'(merr));
        exp_rdy = !rs && !st && (mst == M_FILL || (mst == M_RUN && (!mov || ordy)));
        chk("in_ready", 32'(src_if.ready), 32'(exp_rdy));
        if (mov) begin
            chk("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) chk("out_data", 32'(dst_if.data), 32'(sb[0]));
        end
        if (mov && ordy && sb.size() > 0) void'(sb.pop_front());
        acc  = iv && exp_rdy;
        merr = 1'b0;
        if (rs) begin
            mst = M_IDLE; mov = 1'b0; mfill = 0; mdelay = 0;
            sb.delete(); hist.delete();
        end else if (st) begin
            mov = 1'b0;
            sb.delete();
            if (cd == 0) begin
                merr = 1'b1;
                mst  = M_IDLE;
            end else begin
                mdelay = cd; mfill = 0; mst = M_FILL;
                hist.delete();
            end
        end else if (mst == M_FILL) begin
            if (acc) begin
                hist.push_back(WIDTH'(id));
                mfill++;
                if (mfill == mdelay) mst = M_RUN;
            end
        end else if (mst == M_RUN) begin
            if (acc) begin
                hist.push_back(WIDTH'(id));
                sb.push_back(hist[hist.size() - 1 - mdelay]);
                mov = 1'b1;
            end else if (ordy) begin
                mov = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_delay = '0;
        src_if.valid = 1'b0; src_if.data = '0; dst_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // reset state; input must be ignored in IDLE
        step(1'b0, 0, 1'b1, 16'h1234, 1'b1, 1'b0);
        idle_cycles(1);

        // delay 3, back-to-back
        step(1'b1, 3, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, i, 1'b1, 1'b0);
        idle_cycles(3);

        // delay 4 with a 5-cycle stall in RUN
        step(1'b1, 4, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 100 + i, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 200 + i, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 300 + i, 1'b1, 1'b0);
        idle_cycles(3);

        // maximum delay across two pointer wraps
        step(1'b1, SIZE - 1, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 1200; i++) step(1'b0, 0, 1'b1, int'($urandom_range(0, 65535)), 1'b1, 1'b0);
        idle_cycles(3);

        // zero delay is rejected
        step(1'b1, 0, 1'b1, 5, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 6, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 7, 1'b1, 1'b0);

        // reset mid-RUN with out_valid high, then delay 1
        step(1'b1, 4, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 0, 1'b1, 400 + i, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 450, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 451, 1'b1, 1'b0);
        step(1'b1, 1, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1, 500 + i, 1'b1, 1'b0);
        idle_cycles(2);

        // restart during RUN with a same-cycle input
        step(1'b1, 5, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b1, 550 + i, 1'b1, 1'b0);
        step(1'b1, 2, 1'b1, 16'hdead, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1, 600 + i, 1'b1, 1'b0);
        idle_cycles(2);

        // random valid gaps and back-pressure
        step(1'b1, 7, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++)
            step(1'b0, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 3) != 0), 1'b0);
        idle_cycles(3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
